// File: rtl/mbs_bus_tracer.sv
// ---------------------------------------------------------------------------
// mbs_bus_tracer
//
// Bus trace capture buffer. Stores NCH-channel bus samples into a DEPTH-entry
// trace memory and hands them out oldest-first once the capture is complete.
//
// Capture modes (latched on arm):
//   mode 0 : wait for a trigger hit, then fill the buffer to full.
//   mode 1 : record continuously into a circular buffer, and stop POST_TRIG
//            samples after the trigger. The trigger sample counts as post-trigger
//            sample 1.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   arm          : single-cycle start/restart command
//   mode         : capture mode, sampled on arm
//   trig_value   : trigger compare value on channel TRIG_CH
//   trig_mask    : trigger compare mask (1 = bit compared)
//   smp_valid    : sample strobe
//   smp_data     : sample, channel k at bits [k*DATA_W +: DATA_W]
//   state        : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   count        : number of entries held
//   overflow     : circular capture overwrote an entry since arm
//   rd_valid     : rd_data holds an unread entry (DONE only)
//   rd_data      : oldest unread entry
//   rd_ready     : consumer accepts rd_data
// ---------------------------------------------------------------------------
module mbs_bus_tracer #(
    parameter int DATA_W    = 32,
    parameter int NCH       = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TRIG_CH   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      mode,
    input  logic [DATA_W-1:0]         trig_value,
    input  logic [DATA_W-1:0]         trig_mask,
    input  logic                      smp_valid,
    input  logic [NCH*DATA_W-1:0]     smp_data,
    output logic [1:0]                state,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      rd_valid,
    output logic [NCH*DATA_W-1:0]     rd_data,
    input  logic                      rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] POST_END = CW'(POST_TRIG);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Masked equality compare used for the trigger.
    function automatic logic trig_match(input logic [DATA_W-1:0] ch,
                                        input logic [DATA_W-1:0] val,
                                        input logic [DATA_W-1:0] msk);
        trig_match = ((ch & msk) == (val & msk));
    endfunction

    state_t              state_r,   state_nxt_s;
    logic [AW-1:0]       wr_ptr_r,  wr_ptr_nxt_s;
    logic [CW-1:0]       count_r,   count_nxt_s;
    logic [CW-1:0]       post_r,    post_nxt_s;
    logic                ovf_r,     ovf_nxt_s;
    logic                mode_r,    mode_nxt_s;
    logic                wr_en_s;
    logic                hit_s;
    logic                rd_valid_s;
    logic                pop_s;
    logic [AW-1:0]       rd_addr_s;

    logic [NCH*DATA_W-1:0] mem_r [DEPTH];

    assign hit_s      = smp_valid &&
                        trig_match(smp_data[TRIG_CH*DATA_W +: DATA_W], trig_value, trig_mask);
    assign rd_valid_s = (state_r == ST_DONE) && (count_r != CNT_ZERO);
    assign pop_s      = rd_valid_s && rd_ready;
    // count never exceeds DEPTH, so its low AW bits give the distance mod DEPTH.
    assign rd_addr_s  = wr_ptr_r - count_r[AW-1:0];

    // Next-state, pointer, count and flag computation.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        post_nxt_s   = post_r;
        ovf_nxt_s    = ovf_r;
        mode_nxt_s   = mode_r;
        wr_en_s      = 1'b0;

        if (arm) begin
            // Restart wins over everything, including a same-cycle read or sample.
            state_nxt_s  = ST_ARMED;
            wr_ptr_nxt_s = PTR_ZERO;
            count_nxt_s  = CNT_ZERO;
            post_nxt_s   = CNT_ZERO;
            ovf_nxt_s    = 1'b0;
            mode_nxt_s   = mode;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_ARMED: begin
                    if (!mode_r) begin
                        if (hit_s) begin
                            wr_en_s      = 1'b1;
                            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                            count_nxt_s  = CNT_ONE;
                            state_nxt_s  = ST_CAPTURE;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else if (smp_valid) begin
                        wr_en_s      = 1'b1;
                        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                        if (count_r == CNT_FULL) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            count_nxt_s = count_r + CNT_ONE;
                        end
                        if (hit_s) begin
                            post_nxt_s  = CNT_ONE;
                            state_nxt_s = (POST_END == CNT_ONE) ? ST_DONE : ST_CAPTURE;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (smp_valid) begin
                        wr_en_s      = 1'b1;
                        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                        if (!mode_r) begin
                            count_nxt_s = count_r + CNT_ONE;
                            if ((count_r + CNT_ONE) == CNT_FULL) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = ST_CAPTURE;
                            end
                        end else begin
                            if (count_r == CNT_FULL) begin
                                ovf_nxt_s = 1'b1;
                            end else begin
                                count_nxt_s = count_r + CNT_ONE;
                            end
                            // Later hits do not restart the post-trigger count.
                            post_nxt_s = post_r + CNT_ONE;
                            if ((post_r + CNT_ONE) == POST_END) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = ST_CAPTURE;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    if (pop_s) begin
                        count_nxt_s = count_r - CNT_ONE;
                        if (count_r == CNT_ONE) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            post_r   <= CNT_ZERO;
            ovf_r    <= 1'b0;
            mode_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            post_r   <= post_nxt_s;
            ovf_r    <= ovf_nxt_s;
            mode_r   <= mode_nxt_s;
        end
    end

    // Trace storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_ptr_r] <= smp_data;
        end
    end

    assign state    = state_r;
    assign count    = count_r;
    assign overflow = ovf_r;
    assign rd_valid = rd_valid_s;
    assign rd_data  = mem_r[rd_addr_s];

endmodule

// File: tb/tb_mbs_bus_tracer.sv
// ---------------------------------------------------------------------------
// tb_mbs_bus_tracer
//
// Self-checking bench for mbs_bus_tracer with default parameters. Expected
// trace entries are queued as samples are driven and compared on readout.
// ---------------------------------------------------------------------------
module tb_mbs_bus_tracer;

    localparam int DATA_W = 32;
    localparam int NCH    = 4;
    localparam int DEPTH  = 16;

    logic                  clk;
    logic                  rst;
    logic                  arm;
    logic                  mode;
    logic [DATA_W-1:0]     trig_value;
    logic [DATA_W-1:0]     trig_mask;
    logic                  smp_valid;
    logic [NCH*DATA_W-1:0] smp_data;
    logic [1:0]            state;
    logic [4:0]            count;
    logic                  overflow;
    logic                  rd_valid;
    logic [NCH*DATA_W-1:0] rd_data;
    logic                  rd_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [NCH*DATA_W-1:0] exp_q [$];

    mbs_bus_tracer #(
        .DATA_W(32), .NCH(4), .DEPTH(16), .POST_TRIG(8), .TRIG_CH(1)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode),
        .trig_value(trig_value), .trig_mask(trig_mask),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .state(state), .count(count), .overflow(overflow),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Build a 4-channel sample: data, addr (trigger channel), ctrl, inst.
    function automatic logic [127:0] mk(input logic [31:0] addr);
        mk = {~addr, 32'h0000_0C00 | addr, addr, addr ^ 32'hA5A5_0000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr);
        smp_valid = 1'b1;
        smp_data  = mk(addr);
        step();
        smp_valid = 1'b0;
    endtask

    // Arm with a hitting sample in the same cycle; that sample must be dropped.
    task automatic do_arm(input logic m, input logic [31:0] tv, input logic [31:0] tm);
        mode       = m;
        trig_value = tv;
        trig_mask  = tm;
        arm        = 1'b1;
        smp_valid  = 1'b1;
        smp_data   = mk(tv);
        step();
        arm        = 1'b0;
        smp_valid  = 1'b0;
    endtask

    // Read out entries, optionally toggling rd_ready, with a cycle budget.
    task automatic drain(input bit toggle, input int exp_n);
        int got_n = 0;
        bit stalled = 1'b0;
        logic [127:0] held = '0;
        logic [127:0] e;
        for (int c = 0; c < 200; c++) begin
            if (got_n == exp_n) break;
            rd_ready = toggle ? ((c % 2) == 0) : 1'b1;
            #1;
            if (stalled) chk("rd_stable", rd_data, held);
            if (rd_valid && rd_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                chk("rd_data", rd_data, e);
                got_n++;
                stalled = 1'b0;
            end else if (rd_valid) begin
                held    = rd_data;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            step();
        end
        rd_ready = 1'b0;
        chk("rd_count", 128'(got_n), 128'(exp_n));
        chk("q_empty", 128'(exp_q.size()), 128'd0);
        chk("idle_after_read", 128'(state), 128'd0);
        chk("rd_valid_after_read", 128'(rd_valid), 128'd0);
    endtask

    initial begin
        logic [31:0] list3 [11];
        rst = 1'b1; arm = 1'b0; mode = 1'b0; trig_value = '0; trig_mask = '0;
        smp_valid = 1'b0; smp_data = '0; rd_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_state", 128'(state), 128'd0);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_ovf", 128'(overflow), 128'd0);
        chk("rst_rd_valid", 128'(rd_valid), 128'd0);
        drive(32'h0000_0100);
        chk("idle_ignores", 128'(count), 128'd0);

        // Mode 0: start on trigger, fill to full.
        do_arm(1'b0, 32'h0000_0100, 32'hFFFF_FFFF);
        chk("m0_armed", 128'(state), 128'd1);
        chk("m0_arm_discard", 128'(count), 128'd0);
        chk("m0_armed_rdv", 128'(rd_valid), 128'd0);
        mode = 1'b1;  // must be ignored until next arm
        drive(32'h0000_00F0);
        drive(32'h0000_00F8);
        chk("m0_nohit", 128'(count), 128'd0);
        for (int i = 0; i < 16; i++) begin
            drive(32'h0000_0100 + 32'(4 * i));
            exp_q.push_back(mk(32'h0000_0100 + 32'(4 * i)));
            if (i == 0) begin
                chk("m0_first_state", 128'(state), 128'd2);
                chk("m0_first_count", 128'(count), 128'd1);
            end
        end
        chk("m0_done", 128'(state), 128'd3);
        chk("m0_count", 128'(count), 128'd16);
        chk("m0_ovf", 128'(overflow), 128'd0);
        drive(32'h0000_0200);
        chk("m0_done_nowrite", 128'(count), 128'd16);
        drain(1'b1, 16);

        // Mode 1: long pre-trigger history wraps and overflows.
        do_arm(1'b1, 32'd20, 32'hFFFF_FFFF);
        mode = 1'b0;
        for (int a = 0; a < 28; a++) begin
            drive(32'(a));
            exp_q.push_back(mk(32'(a)));
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            if (a == 20) chk("m1_capture", 128'(state), 128'd2);
        end
        chk("m1_done", 128'(state), 128'd3);
        chk("m1_count", 128'(count), 128'd16);
        chk("m1_ovf", 128'(overflow), 128'd1);
        drain(1'b0, 16);

        // Mode 1: short history, repeated hit must not restart post count.
        do_arm(1'b1, 32'd100, 32'hFFFF_FFFF);
        mode = 1'b0;
        list3 = '{32'd50, 32'd51, 32'd52, 32'd100, 32'd101, 32'd102,
                  32'd100, 32'd104, 32'd105, 32'd106, 32'd107};
        for (int i = 0; i < 11; i++) begin
            drive(list3[i]);
            exp_q.push_back(mk(list3[i]));
        end
        chk("m1s_done", 128'(state), 128'd3);
        chk("m1s_count", 128'(count), 128'd11);
        chk("m1s_ovf", 128'(overflow), 128'd0);
        rd_ready = 1'b1;
        #1;
        chk("m1s_rd0", rd_data, exp_q.pop_front());
        step();
        chk("m1s_rd1", rd_data, exp_q.pop_front());
        step();
        chk("m1s_count9", 128'(count), 128'd9);
        // Arm in DONE with a same-cycle read: the read must not happen.
        do_arm(1'b0, 32'h0000_0100, 32'hFFFF_FFFF);
        rd_ready = 1'b0;
        exp_q.delete();
        chk("rearm_state", 128'(state), 128'd1);
        chk("rearm_count", 128'(count), 128'd0);
        chk("rearm_ovf", 128'(overflow), 128'd0);

        // Reset in the middle of a capture.
        drive(32'h0000_0100);
        drive(32'h0000_0104);
        drive(32'h0000_0108);
        chk("mid_state", 128'(state), 128'd2);
        chk("mid_count", 128'(count), 128'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_state", 128'(state), 128'd0);
        chk("rst2_count", 128'(count), 128'd0);
        chk("rst2_rdv", 128'(rd_valid), 128'd0);
        drive(32'h0000_0100);
        drive(32'h0000_0104);
        chk("rst2_ignore_cnt", 128'(count), 128'd0);
        chk("rst2_ignore_st", 128'(state), 128'd0);

        // Zero mask: any valid sample hits, idle strobe does nothing.
        do_arm(1'b0, 32'hDEAD_BEEF, 32'h0000_0000);
        step();
        chk("mask0_wait", 128'(count), 128'd0);
        drive(32'h0000_0007);
        chk("mask0_state", 128'(state), 128'd2);
        chk("mask0_count", 128'(count), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
